// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_pkg
// Brief    : Shared widths, reset PC and fetch state encodings for the fetch stage.
// Revision : 1.0
// ============================================================================
package instr_fetch_unit_pkg;

   localparam int unsigned DEF_ADDR_W    = 16;
   localparam int unsigned DEF_INSTR_W   = 16;
   localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
   localparam int unsigned DEF_BUF_DEPTH = 2;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t ST_IDLE   = 2'b00;
   localparam fetch_state_t ST_FETCH  = 2'b01;
   localparam fetch_state_t ST_HALTED = 2'b10;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_fetch_buffer
// Brief    : Small FIFO of {pc, instr} entries with flush; push+pop in one cycle.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit_fetch_buffer #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] head_data,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_W'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage: PC, RAM read issue, prefetch capture and decode handshake.
// Revision : 1.0
// ============================================================================
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W    = DEF_ADDR_W,
   parameter int unsigned       INSTR_W   = DEF_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
   parameter int unsigned       BUF_DEPTH = DEF_BUF_DEPTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               halt,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd,
   input  logic [INSTR_W-1:0] mem_data,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_data,
   output logic [ADDR_W-1:0]  instr_pc,
   input  logic               instr_ready,
   output logic               busy
);

   localparam int unsigned CNT_W   = $clog2(BUF_DEPTH) + 1;
   localparam int unsigned OCC_W   = CNT_W + 1;
   localparam int unsigned ENTRY_W = ADDR_W + INSTR_W;
   localparam logic [OCC_W-1:0] C_DEPTH = OCC_W'(BUF_DEPTH);

   fetch_state_t        state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                mem_rd_q, mem_rd_d;

   logic                deq, push, pop, room, issue;
   logic [OCC_W-1:0]    occupancy;
   logic [CNT_W-1:0]    buf_count;
   logic                buf_empty, buf_full;
   logic [ENTRY_W-1:0]  head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start && !halt) state_d = ST_FETCH;
         ST_FETCH:  if (halt)           state_d = ST_HALTED;
         ST_HALTED: if (start && !halt) state_d = ST_FETCH;
         default:                       state_d = ST_IDLE;
      endcase
   end

   // Issue is judged against the state being entered, so a start edge already
   // launches the first read; the word lands one edge later. A read is only
   // launched when the buffer is sure to have a slot for it on return.
   always_comb begin
      deq       = !buf_empty && instr_ready;
      pop       = deq && !redirect_valid;
      push      = mem_rd_q && !redirect_valid;
      occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, mem_rd_q} - {{CNT_W{1'b0}}, deq};
      room      = !(buf_full && !deq) && (occupancy < C_DEPTH);
      issue     = (state_d == ST_FETCH) && !redirect_valid && room;
      mem_rd_d   = issue;
      mem_addr_d = issue ? pc_q : mem_addr_q;
      if (redirect_valid) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d = pc_q + 1'b1;
      end else begin
         pc_d = pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         mem_addr_q <= RESET_PC;
         mem_rd_q   <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         mem_rd_q   <= mem_rd_d;
      end
   end

   instr_fetch_unit_fetch_buffer #(
      .WIDTH (ENTRY_W),
      .DEPTH (BUF_DEPTH)
   ) u_buffer (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .flush     (redirect_valid),
      .push_data ({mem_addr_q, mem_data}),
      .head_data (head),
      .count     (buf_count),
      .empty     (buf_empty),
      .full      (buf_full)
   );

   assign mem_addr    = mem_addr_q;
   assign mem_rd      = mem_rd_q;
   assign instr_valid = !buf_empty;
   assign instr_pc    = buf_empty ? '0 : head[ENTRY_W-1:INSTR_W];
   assign instr_data  = buf_empty ? '0 : head[INSTR_W-1:0];
   assign busy        = (state_q == ST_FETCH) || mem_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench; decode side compared to a program-order PC model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n, start, halt, redirect_valid, instr_ready;
   logic [15:0] redirect_pc;
   logic [15:0] mem_addr, mem_data, instr_data, instr_pc;
   logic        mem_rd, instr_valid, busy;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_pc;

   always #5 clk = ~clk;

   function automatic logic [15:0] ram_word(input logic [15:0] a);
      return 16'hA000 + a;
   endfunction

   // RAM returns the addressed word; garbage whenever no read is pending.
   assign mem_data = mem_rd ? ram_word(mem_addr) : 16'hDEAD;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .mem_addr       (mem_addr),
      .mem_rd         (mem_rd),
      .mem_data       (mem_data),
      .instr_valid    (instr_valid),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .busy           (busy)
   );

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 16'h0; instr_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
      checks++; if (instr_pc !== 16'h0000 || instr_data !== 16'h0000) begin errors++; $display("FAIL reset_instr: got pc %h data %h expected 0000/0000", instr_pc, instr_data); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (mem_rd !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_fetch: got rd %b busy %b expected 0/0", mem_rd, busy); end
   endtask

   task automatic test_stream();
      exp_pc = 16'h0000;
      instr_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got valid %b expected 0 one edge after start", instr_valid); end
      checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL stream_first_issue: got rd %b addr %h expected 1/0000", mem_rd, mem_addr); end
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== ram_word(exp_pc)) begin
            errors++;
            $display("FAIL stream_word: got v %b pc %h data %h expected 1 pc %h data %h", instr_valid, instr_pc, instr_data, exp_pc, ram_word(exp_pc));
         end
         exp_pc = exp_pc + 16'd1;
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 1'b0;
      repeat (6) @(negedge clk);
      checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL bp_mem_rd: got %b expected 0", mem_rd); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== exp_pc) begin errors++; $display("FAIL bp_head: got v %b pc %h expected 1 pc %h", instr_valid, instr_pc, exp_pc); end
      checks++; if (mem_addr !== exp_pc + 16'd1) begin errors++; $display("FAIL bp_two_buffered: got last addr %h expected %h", mem_addr, exp_pc + 16'd1); end
      instr_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== ram_word(exp_pc)) begin
            errors++;
            $display("FAIL bp_drain: got v %b pc %h data %h expected 1 pc %h data %h", instr_valid, instr_pc, instr_data, exp_pc, ram_word(exp_pc));
         end
         exp_pc = exp_pc + 16'd1;
         @(negedge clk);
      end
   endtask

   task automatic test_redirect(input logic [15:0] target, input int nwords);
      instr_ready    = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = target;
      exp_pc         = target;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble%0d: got valid %b expected 0", k, instr_valid); end
         @(negedge clk);
      end
      for (int i = 0; i < nwords; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== ram_word(exp_pc)) begin
            errors++;
            $display("FAIL redir_word: got v %b pc %h data %h expected 1 pc %h data %h", instr_valid, instr_pc, instr_data, exp_pc, ram_word(exp_pc));
         end
         exp_pc = exp_pc + 16'd1;
         @(negedge clk);
      end
   endtask

   task automatic test_halt();
      instr_ready = 1'b1;
      halt = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (instr_valid) begin
            checks++;
            if (instr_pc !== exp_pc || instr_data !== ram_word(exp_pc)) begin
               errors++;
               $display("FAIL halt_drain: got pc %h data %h expected pc %h data %h", instr_pc, instr_data, exp_pc, ram_word(exp_pc));
            end
            exp_pc = exp_pc + 16'd1;
         end
         @(negedge clk);
         checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL halt_mem_rd: got %b expected 0 at cycle %0d", mem_rd, i); end
      end
      checks++; if (busy !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_idle: got busy %b valid %b expected 0/0", busy, instr_valid); end
      halt  = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (mem_rd !== 1'b1 || mem_addr !== exp_pc) begin errors++; $display("FAIL halt_resume_issue: got rd %b addr %h expected 1/%h", mem_rd, mem_addr, exp_pc); end
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr_data !== ram_word(exp_pc)) begin
            errors++;
            $display("FAIL halt_resume_word: got v %b pc %h data %h expected 1 pc %h data %h", instr_valid, instr_pc, instr_data, exp_pc, ram_word(exp_pc));
         end
         exp_pc = exp_pc + 16'd1;
         @(negedge clk);
      end
   endtask

   task automatic test_async_reset();
      #2;
      checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL areset_precond: got rd %b expected 1", mem_rd); end
      rst_n = 1'b0;
      #1;
      checks++; if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL areset_ctrl: got rd %b v %b busy %b expected 0/0/0", mem_rd, instr_valid, busy); end
      checks++; if (mem_addr !== 16'h0000 || instr_pc !== 16'h0000 || instr_data !== 16'h0000) begin errors++; $display("FAIL areset_data: got addr %h pc %h data %h expected 0000", mem_addr, instr_pc, instr_data); end
      @(negedge clk);
      rst_n  = 1'b1;
      exp_pc = 16'h0000;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000 || instr_data !== 16'hA000) begin errors++; $display("FAIL areset_restart: got v %b pc %h data %h expected 1 0000 A000", instr_valid, instr_pc, instr_data); end
      exp_pc = 16'h0001;
      @(negedge clk);
   endtask

   task automatic test_random();
      int accepted = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         instr_ready    = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 39) == 0);
         if (redirect_valid) redirect_pc = 16'($urandom);
         if (halt) begin
            if ($urandom_range(0, 7) == 0) halt = 1'b0;
         end else if ($urandom_range(0, 49) == 0) begin
            halt = 1'b1;
         end
         start = ($urandom_range(0, 5) == 0);
         if (redirect_valid) begin
            exp_pc = redirect_pc;
         end else if (instr_valid && instr_ready) begin
            checks++;
            if (instr_pc !== exp_pc || instr_data !== ram_word(exp_pc)) begin
               errors++;
               $display("FAIL random_word: cycle %0d got pc %h data %h expected pc %h data %h", cyc, instr_pc, instr_data, exp_pc, ram_word(exp_pc));
            end
            exp_pc = exp_pc + 16'd1;
            accepted++;
         end
         @(negedge clk);
         redirect_valid = 1'b0;
         start = 1'b0;
      end
      halt = 1'b0;
      checks++; if (accepted < 100) begin errors++; $display("FAIL random_progress: got %0d words expected at least 100", accepted); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect(16'h0040, 4);
      test_redirect(16'hFFFE, 5);
      test_halt();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
